sram_1r1w_param: RTL and testbench

SRAM_1R1W_PARAM -- requirements
Module: sram_1r1w_param

---
 rtl/sram_pkg.sv | 32 +++
 rtl/sram_1r1w_array.sv | 41 ++++
 rtl/sram_1r1w_param.sv | 179 +++++++++++++++++
 tb/tb_sram_1r1w_param.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1R1W SRAM wrapper: the init FSM state
// encoding and the lane-masked word merge used by the read bypass path.
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Widest word the merge helper handles; callers size-cast in and out.
    localparam int MERGE_MAX_W = 1024;
    localparam int MERGE_IW    = $clog2(MERGE_MAX_W);

    // Per-lane merge: lanes whose mask bit is set take new_word, others keep
    // old_word. Lane i covers bits [i*gran +: gran].
    function automatic logic [MERGE_MAX_W-1:0] mask_merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_word,
        input logic [MERGE_MAX_W-1:0] lane_mask,
        input int                     gran
    );
        logic [MERGE_MAX_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MERGE_MAX_W; b++) begin
            if (lane_mask[MERGE_IW'(b / gran)]) begin
                merged[b] = new_word[b];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_1r1w_array.sv
// Plain storage array: one masked write port, one registered read port,
// no reset on contents. Kept free of control logic so a hard macro can
// take its place without touching the wrapper.
module sram_1r1w_array #(
    parameter int DEPTH     = 17,
    parameter int WIDTH     = 64,
    parameter int MASK_GRAN = 8,
    parameter int AW        = 5,
    parameter int MW        = 8
) (
    input  logic             clock,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [MW-1:0]    wmask
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    // Masked write and registered read; a same-address read returns the
    // pre-write contents (the wrapper adds the write-first bypass).
    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < MW; i++) begin
                if (wmask[i]) begin
                    mem[waddr][i*MASK_GRAN +: MASK_GRAN] <= wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sram_1r1w_param.sv
// 1R1W SRAM wrapper: zero-fill sequence after reset, lane-masked writes,
// write-first same-address bypass, out-of-range handling and an optional
// output pipeline register around the raw storage array.
module sram_1r1w_param
    import sram_pkg::*;
#(
    parameter  int DEPTH     = 17,
    parameter  int WIDTH     = 64,
    parameter  int MASK_GRAN = 8,
    parameter  int OUT_REG   = 0,
    localparam int AW        = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH),
    localparam int MW        = WIDTH / MASK_GRAN
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [MW-1:0]    wr_mask,
    output logic             init_busy
);

    state_t           state_reg;
    logic [AW-1:0]    clr_cnt_reg;
    logic             init_busy_reg;

    logic             ready;
    logic             wr_in_range;
    logic             rd_in_range;

    logic             arr_re;
    logic             arr_we;
    logic [AW-1:0]    arr_waddr;
    logic [WIDTH-1:0] arr_wdata;
    logic [MW-1:0]    arr_wmask;
    logic [WIDTH-1:0] arr_rdata;

    logic             s1_valid_reg;
    logic             s1_oor_reg;
    logic [MW-1:0]    s1_byp_mask_reg;
    logic [WIDTH-1:0] s1_byp_data_reg;
    logic [WIDTH-1:0] s1_word;

    assign ready       = (state_reg == READY);
    assign wr_in_range = (32'(wr_addr) < 32'(DEPTH));
    assign rd_in_range = (32'(rd_addr) < 32'(DEPTH));
    assign init_busy   = init_busy_reg;

    // Init FSM: sweep every address once with zeros, then serve users.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= CLEAR;
            clr_cnt_reg   <= '0;
            init_busy_reg <= 1'b1;
        end else begin
            case (state_reg)
                CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (clr_cnt_reg == AW'(DEPTH - 1)) begin
                        state_reg     <= READY;
                        init_busy_reg <= 1'b0;
                    end
                end
                READY: begin
                    state_reg <= READY;
                end
                default: begin
                    state_reg     <= CLEAR;
                    clr_cnt_reg   <= '0;
                    init_busy_reg <= 1'b1;
                end
            endcase
        end
    end

    // Write port steering: the clear sweep owns the port until READY.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = wr_addr;
        arr_wdata = wr_data;
        arr_wmask = wr_mask;
        if (state_reg == CLEAR) begin
            arr_we    = 1'b1;
            arr_waddr = clr_cnt_reg;
            arr_wdata = '0;
            arr_wmask = '1;
        end else begin
            arr_we    = wr_en & wr_in_range;
        end
    end

    assign arr_re = rd_en & rd_in_range;

    sram_1r1w_array #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .MASK_GRAN (MASK_GRAN),
        .AW        (AW),
        .MW        (MW)
    ) u_array (
        .clock (clock),
        .re    (arr_re),
        .raddr (rd_addr),
        .rdata (arr_rdata),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .wmask (arr_wmask)
    );

    // Read stage 1: remember validity, range and any same-address write so
    // the lanes written this cycle can override the array's old data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_reg    <= 1'b0;
            s1_oor_reg      <= 1'b0;
            s1_byp_mask_reg <= '0;
            s1_byp_data_reg <= '0;
        end else begin
            s1_valid_reg    <= rd_en & ready;
            s1_oor_reg      <= ~rd_in_range;
            s1_byp_mask_reg <= (ready && wr_en && wr_in_range && (wr_addr == rd_addr)) ? wr_mask : '0;
            s1_byp_data_reg <= wr_data;
        end
    end

    // Completed read word: zero when out of range, else write-first merge.
    always_comb begin
        s1_word = WIDTH'(mask_merge(MERGE_MAX_W'(arr_rdata),
                                    MERGE_MAX_W'(s1_byp_data_reg),
                                    MERGE_MAX_W'(s1_byp_mask_reg),
                                    MASK_GRAN));
        if (s1_oor_reg) begin
            s1_word = '0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] out_data_reg;
            logic             out_valid_reg;

            // Extra output stage; data only moves on a completing read.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    out_data_reg  <= '0;
                    out_valid_reg <= 1'b0;
                end else begin
                    out_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        out_data_reg <= s1_word;
                    end
                end
            end

            assign rd_data  = out_data_reg;
            assign rd_valid = out_valid_reg;
        end else begin : g_no_out_reg
            logic [WIDTH-1:0] hold_reg;

            // Last presented word, replayed on cycles with no completing read.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    hold_reg <= '0;
                end else begin
                    hold_reg <= rd_data;
                end
            end

            assign rd_data  = s1_valid_reg ? s1_word : hold_reg;
            assign rd_valid = s1_valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sram_1r1w_param.sv
// Self-checking bench: two instances (OUT_REG=0 and OUT_REG=1) share one
// stimulus stream and are checked against an array-based reference model.
module tb_sram_1r1w_param;

    localparam int DEPTH = 17;
    localparam int WIDTH = 64;
    localparam int GRAN  = 8;
    localparam int MW    = WIDTH / GRAN;
    localparam int AW    = 5;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             rd_en = 1'b0;
    logic [AW-1:0]    rd_addr = '0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [MW-1:0]    wr_mask = '0;

    logic [WIDTH-1:0] rd_data0, rd_data1;
    logic             rd_valid0, rd_valid1;
    logic             init_busy0, init_busy1;

    always #5 clock = ~clock;

    sram_1r1w_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(GRAN), .OUT_REG(0)) u_dut0 (
        .clock(clock), .reset(reset),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .init_busy(init_busy0)
    );

    sram_1r1w_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(GRAN), .OUT_REG(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .init_busy(init_busy1)
    );

    // Reference model state
    logic [WIDTH-1:0] mem_m [DEPTH];
    int               busy_left;
    logic [WIDTH-1:0] last0, last1, pend_d;
    logic             pend_v;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [WIDTH-1:0] apply_mask(input logic [WIDTH-1:0] old_w,
                                                    input logic [WIDTH-1:0] new_w,
                                                    input logic [MW-1:0] m);
        logic [WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < MW; i++) begin
            if (m[i]) r[i*GRAN +: GRAN] = new_w[i*GRAN +: GRAN];
        end
        return r;
    endfunction

    // One clock of stimulus, model update and comparison of both instances.
    task automatic step(input logic re, input logic [AW-1:0] ra,
                        input logic we, input logic [AW-1:0] wa,
                        input logic [WIDTH-1:0] wd, input logic [MW-1:0] wm);
        logic             rdy, req_v;
        logic [WIDTH-1:0] req_d;
        @(negedge clock);
        rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
        rdy = (busy_left == 0);
        if (rdy && we && (int'(wa) < DEPTH)) mem_m[wa] = apply_mask(mem_m[wa], wd, wm);
        req_v = re && rdy;
        req_d = '0;
        if (int'(ra) < DEPTH) req_d = mem_m[ra];
        @(posedge clock);
        #1;
        if (busy_left > 0) busy_left--;
        if (req_v) last0 = req_d;
        if (pend_v) last1 = pend_d;
        vectors++;
        if (rd_valid0 !== req_v) begin
            miscompares++;
            $display("FAIL step_valid0 t=%0t got %b exp %b", $time, rd_valid0, req_v);
        end
        vectors++;
        if (rd_data0 !== last0) begin
            miscompares++;
            $display("FAIL step_data0 t=%0t got %h exp %h", $time, rd_data0, last0);
        end
        vectors++;
        if (rd_valid1 !== pend_v) begin
            miscompares++;
            $display("FAIL step_valid1 t=%0t got %b exp %b", $time, rd_valid1, pend_v);
        end
        vectors++;
        if (rd_data1 !== last1) begin
            miscompares++;
            $display("FAIL step_data1 t=%0t got %h exp %h", $time, rd_data1, last1);
        end
        vectors++;
        if ((init_busy0 !== (busy_left != 0)) || (init_busy1 !== (busy_left != 0))) begin
            miscompares++;
            $display("FAIL step_busy t=%0t got %b/%b exp %b", $time, init_busy0, init_busy1, busy_left != 0);
        end
        pend_v = req_v;
        pend_d = req_d;
        $display("cycle t=%0t re=%b ra=%0d we=%b wa=%0d wm=%h v0=%b d0=%h v1=%b d1=%h busy=%b",
                 $time, re, ra, we, wa, wm, rd_valid0, rd_data0, rd_valid1, rd_data1, init_busy0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    // Assert reset away from the edge, check reset outputs, release after a posedge.
    task automatic apply_reset(input int hold_cycles);
        @(negedge clock);
        reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        #1;
        vectors++;
        if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0 || rd_data0 !== '0 || rd_data1 !== '0
            || init_busy0 !== 1'b1 || init_busy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b/%b d=%h/%h busy=%b/%b exp v=0 d=0 busy=1",
                     rd_valid0, rd_valid1, rd_data0, rd_data1, init_busy0, init_busy1);
        end
        repeat (hold_cycles) @(posedge clock);
        #1;
        vectors++;
        if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0 || rd_data0 !== '0 || rd_data1 !== '0) begin
            miscompares++;
            $display("FAIL reset_hold got v=%b/%b d=%h/%h exp zeros", rd_valid0, rd_valid1, rd_data0, rd_data1);
        end
        reset = 1'b0;
        busy_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        last0 = '0; last1 = '0; pend_v = 1'b0; pend_d = '0;
        $display("reset released t=%0t", $time);
    endtask

    // Run idle cycles until init_busy drops, returning how many cycles it was high.
    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (init_busy0 !== 1'b1) break;
            cnt++;
            idle(1);
        end
    endtask

    task automatic test_reset();
        int cnt, nvalid;
        apply_reset(2);
        count_busy(cnt);
        vectors++;
        if (cnt != DEPTH) begin
            miscompares++;
            $display("FAIL busy_len got %0d exp %0d", cnt, DEPTH);
        end
        nvalid = 0;
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b1, AW'(a), 1'b0, '0, '0, '0);
            if (rd_valid0 === 1'b1 && rd_data0 === '0) nvalid++;
        end
        idle(2);
        vectors++;
        if (nvalid != DEPTH) begin
            miscompares++;
            $display("FAIL clear_reads got %0d zero reads exp %0d", nvalid, DEPTH);
        end
    endtask

    task automatic test_mask();
        step(1'b0, '0, 1'b1, 5'd5, 64'h0123456789ABCDEF, 8'hFF);
        step(1'b0, '0, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        step(1'b1, 5'd5, 1'b0, '0, '0, '0);
        vectors++;
        if (rd_data0 !== 64'h01234567FFFFFFFF) begin
            miscompares++;
            $display("FAIL mask_merge0 got %h exp %h", rd_data0, 64'h01234567FFFFFFFF);
        end
        idle(1);
        vectors++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== 64'h01234567FFFFFFFF) begin
            miscompares++;
            $display("FAIL mask_merge1 got v=%b d=%h exp v=1 d=%h", rd_valid1, rd_data1, 64'h01234567FFFFFFFF);
        end
        step(1'b0, '0, 1'b1, 5'd6, 64'h1111_2222_3333_4444, 8'h00);
        step(1'b1, 5'd6, 1'b0, '0, '0, '0);
        vectors++;
        if (rd_data0 !== '0) begin
            miscompares++;
            $display("FAIL mask_zero got %h exp 0", rd_data0);
        end
        idle(1);
    endtask

    task automatic test_same_cycle();
        step(1'b1, 5'd3, 1'b1, 5'd3, {8{8'hAA}}, 8'h01);
        vectors++;
        if (rd_valid0 !== 1'b1 || rd_data0 !== 64'h00000000000000AA) begin
            miscompares++;
            $display("FAIL write_first got v=%b d=%h exp v=1 d=%h", rd_valid0, rd_data0, 64'hAA);
        end
        step(1'b1, 5'd3, 1'b0, '0, '0, '0);
        vectors++;
        if (rd_data1 !== 64'h00000000000000AA) begin
            miscompares++;
            $display("FAIL write_first1 got %h exp %h", rd_data1, 64'hAA);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [4:0]       vpat;
        logic [WIDTH-1:0] seen [3];
        step(1'b0, '0, 1'b1, 5'd1, 64'h1111, 8'hFF);
        step(1'b0, '0, 1'b1, 5'd2, 64'h2222, 8'hFF);
        step(1'b0, '0, 1'b1, 5'd3, 64'h3333, 8'hFF);
        vpat = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step(1'b1, AW'(i + 1), 1'b0, '0, '0, '0);
            else idle(1);
            vpat[i] = rd_valid1;
            if (i >= 1 && i <= 3) seen[i-1] = rd_data1;
        end
        vectors++;
        if (vpat !== 5'b01110) begin
            miscompares++;
            $display("FAIL b2b_valid got %b exp %b", vpat, 5'b01110);
        end
        vectors++;
        if (seen[0] !== 64'h1111 || seen[1] !== 64'h2222 || seen[2] !== 64'h3333) begin
            miscompares++;
            $display("FAIL b2b_order got %h %h %h exp 1111 2222 3333", seen[0], seen[1], seen[2]);
        end
    endtask

    task automatic test_out_of_range();
        step(1'b0, '0, 1'b1, 5'd4, 64'hDEAD_BEEF_0404_0404, 8'hFF);
        step(1'b0, '0, 1'b1, 5'd20, 64'h5, 8'hFF);
        step(1'b1, 5'd20, 1'b0, '0, '0, '0);
        vectors++;
        if (rd_valid0 !== 1'b1 || rd_data0 !== '0) begin
            miscompares++;
            $display("FAIL oor_read got v=%b d=%h exp v=1 d=0", rd_valid0, rd_data0);
        end
        step(1'b1, 5'd4, 1'b0, '0, '0, '0);
        vectors++;
        if (rd_data0 !== 64'hDEAD_BEEF_0404_0404) begin
            miscompares++;
            $display("FAIL oor_neighbor got %h exp %h", rd_data0, 64'hDEAD_BEEF_0404_0404);
        end
        idle(2);
    endtask

    task automatic test_reset_abort_ready();
        int cnt;
        step(1'b1, 5'd4, 1'b0, '0, '0, '0);
        apply_reset(1);
        vectors++;
        if (rd_valid1 !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_inflight got v=%b exp 0", rd_valid1);
        end
        count_busy(cnt);
        vectors++;
        if (cnt != DEPTH) begin
            miscompares++;
            $display("FAIL abort_busy_len got %0d exp %0d", cnt, DEPTH);
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        step(1'b0, '0, 1'b1, 5'd2, 64'h7, 8'hFF);
        step(1'b1, 5'd2, 1'b0, '0, '0, '0);
        vectors++;
        if (rd_data0 !== 64'h7) begin
            miscompares++;
            $display("FAIL pre_reset_write got %h exp 7", rd_data0);
        end
        apply_reset(1);
        idle(7);
        apply_reset(1);
        count_busy(cnt);
        vectors++;
        if (cnt != DEPTH) begin
            miscompares++;
            $display("FAIL restart_busy_len got %0d exp %0d", cnt, DEPTH);
        end
        step(1'b1, 5'd2, 1'b0, '0, '0, '0);
        vectors++;
        if (rd_valid0 !== 1'b1 || rd_data0 !== '0) begin
            miscompares++;
            $display("FAIL restart_cleared got v=%b d=%h exp v=1 d=0", rd_valid0, rd_data0);
        end
        idle(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ra, wa;
            ra = AW'($urandom_range(0, 23));
            wa = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, 23));
            step(($urandom_range(0, 3) != 0), ra,
                 ($urandom_range(0, 1) != 0), wa,
                 {$urandom, $urandom}, MW'($urandom));
        end
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        busy_left = DEPTH; last0 = '0; last1 = '0; pend_v = 1'b0; pend_d = '0;
        test_reset();
        test_mask();
        test_same_cycle();
        test_back_to_back();
        test_out_of_range();
        test_reset_abort_ready();
        test_random();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
